// File: rtl/baud_rate_ctrl_if.sv
// Rate-select request, UART busy status and the baud enables/status returned
// by baud_rate_ctrl.
interface baud_rate_ctrl_if;
  logic [2:0] sel;
  logic       tx_busy;
  logic       rx_busy;
  logic       tick16;
  logic       tick1;
  logic [2:0] active_sel;
  logic       uart_hold;
  logic       rate_changed;
  logic       switch_forced;

  modport master (
    output sel, tx_busy, rx_busy,
    input  tick16, tick1, active_sel, uart_hold, rate_changed, switch_forced
  );

  modport slave (
    input  sel, tx_busy, rx_busy,
    output tick16, tick1, active_sel, uart_hold, rate_changed, switch_forced
  );
endinterface

// File: rtl/baud_rate_ctrl.sv
// Baud-rate controller: 16x/1x enable generation plus a glitch-free divisor
// switch that waits for both UART directions to go idle (or a timeout).
module baud_rate_ctrl #(
  parameter int unsigned CLK_FREQ    = 12_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_200_000
) (
  input  logic              clk,
  input  logic              rst,
  baud_rate_ctrl_if.slave   bus
);

  localparam int unsigned DIV0  = (CLK_FREQ + 8 * 9600)   / (16 * 9600);
  localparam int unsigned DIV1  = (CLK_FREQ + 8 * 19200)  / (16 * 19200);
  localparam int unsigned DIV2  = (CLK_FREQ + 8 * 38400)  / (16 * 38400);
  localparam int unsigned DIV3  = (CLK_FREQ + 8 * 57600)  / (16 * 57600);
  localparam int unsigned DIV4  = (CLK_FREQ + 8 * 115200) / (16 * 115200);
  localparam int unsigned DIV_W = $clog2(DIV0 + 1);
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, PEND, LOAD} state_t;

  function automatic logic [DIV_W-1:0] div_of(input logic [2:0] s);
    case (s)
      3'd1:    div_of = DIV_W'(DIV1);
      3'd2:    div_of = DIV_W'(DIV2);
      3'd3:    div_of = DIV_W'(DIV3);
      3'd4:    div_of = DIV_W'(DIV4);
      default: div_of = DIV_W'(DIV0);
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [2:0]       target, tgt_eff, active_q;
  logic [TO_W-1:0]  to_cnt;
  logic             sel_ok, forced, load_now;
  logic             hold_nxt, rc_nxt, sf_nxt;
  logic             hold_q, rc_q, sf_q, tick16_q, tick1_q;
  logic [DIV_W-1:0] divisor, div_cnt, new_div;
  logic [3:0]       sub_cnt;

  assign sel_ok  = (bus.sel <= 3'd4);
  // An invalid sel never disturbs the captured target.
  assign tgt_eff = sel_ok ? bus.sel : target;
  assign new_div = div_of(tgt_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      target <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == PEND)
        target <= tgt_eff;
      if (state == PEND && state_nxt == PEND)
        to_cnt <= to_cnt + TO_W'(1);
      else
        to_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    forced    = 1'b0;
    case (state)
      IDLE: if (sel_ok && bus.sel != active_q) state_nxt = PEND;
      PEND: begin
        if (sel_ok && bus.sel == active_q) begin
          state_nxt = IDLE;
        end else if (!bus.tx_busy && !bus.rx_busy) begin
          state_nxt = LOAD;
        end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = LOAD;
          forced    = 1'b1;
        end
      end
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The divisor swap is committed on the edge that enters LOAD, so the LOAD
  // cycle itself already shows the new rate with rate_changed high.
  always_comb begin
    load_now = (state == PEND) && (state_nxt == LOAD);
    hold_nxt = (state_nxt == PEND);
    rc_nxt   = load_now;
    sf_nxt   = load_now && forced;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      divisor  <= DIV_W'(DIV0);
      div_cnt  <= DIV_W'(DIV0 - 1);
      sub_cnt  <= '0;
      tick16_q <= 1'b0;
      tick1_q  <= 1'b0;
      hold_q   <= 1'b0;
      rc_q     <= 1'b0;
      sf_q     <= 1'b0;
    end else begin
      hold_q <= hold_nxt;
      rc_q   <= rc_nxt;
      sf_q   <= sf_nxt;
      if (load_now) begin
        active_q <= tgt_eff;
        divisor  <= new_div;
        div_cnt  <= new_div - DIV_W'(1);
        sub_cnt  <= '0;
        tick16_q <= 1'b0;
        tick1_q  <= 1'b0;
      end else if (div_cnt == '0) begin
        div_cnt  <= divisor - DIV_W'(1);
        sub_cnt  <= sub_cnt + 4'd1;
        tick16_q <= 1'b1;
        tick1_q  <= (sub_cnt == 4'd15);
      end else begin
        div_cnt  <= div_cnt - DIV_W'(1);
        tick16_q <= 1'b0;
        tick1_q  <= 1'b0;
      end
    end
  end

  assign bus.tick16        = tick16_q;
  assign bus.tick1         = tick1_q;
  assign bus.active_sel    = active_q;
  assign bus.uart_hold     = hold_q;
  assign bus.rate_changed  = rc_q;
  assign bus.switch_forced = sf_q;

endmodule

// File: doc/baud_rate_ctrl.md
Name: baud_rate_ctrl

Overview:
Baud-rate controller between the baud selection register and the UART TX/RX datapath. It takes the requested 3-bit rate select, waits until both UART directions are idle (or a timeout expires), then atomically switches the divisor. It generates the 16x oversample enable and the 1x bit enable consumed by the UART engines. During a pending switch it raises a hold so TX does not start a new frame at the old rate.

Parameters:
CLK_FREQ, 12_000_000, system clock in Hz (Cmod A7 oscillator).
TIMEOUT_CYC, 1_200_000, clk cycles to wait for idle before forcing a switch (100 ms at default CLK_FREQ).
DIVn (derived localparams, not overridable): DIVn = (CLK_FREQ + 8*BAUDn) / (16*BAUDn), integer division. Bauds are 9600/19200/38400/57600/115200 for sel 0..4, giving 78/39/20/13/7 at default CLK_FREQ.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
sel  in  3  requested rate select; 0..4 valid, 5..7 invalid
tx_busy  in  1  TX frame in progress
rx_busy  in  1  RX frame in progress
tick16  out  1  one-clk enable at 16x baud
tick1  out  1  one-clk enable at 1x baud; coincident with every 16th tick16
active_sel  out  3  select currently driving the divisor
uart_hold  out  1  high while a switch is pending; TX must not start a frame
rate_changed  out  1  one-clk pulse when the new divisor takes effect
switch_forced  out  1  one-clk pulse coincident with rate_changed when the switch was caused by timeout

Behaviour:
- Reset values: active_sel=0, divisor=DIV0, div_cnt=DIV0-1, sub_cnt=0, timeout counter=0, state=IDLE. tick16, tick1, uart_hold, rate_changed and switch_forced are all 0.
- Divider: div_cnt decrements every clk. When div_cnt==0 it reloads divisor-1 and tick16 is driven high for exactly one clk on that cycle. Period is exactly divisor clks. The first tick16 comes DIV0 clks after reset is released.
- sub_cnt (4 bit) increments on each tick16. tick1 = tick16 && sub_cnt==15. sub_cnt wraps 15->0.
- All outputs are registered.
- FSM IDLE:
  - If sel is valid (<=4) and sel != active_sel: capture target=sel, go to PEND, assert uart_hold from the next cycle.
  - Invalid sel is ignored; state and outputs are unchanged.
- FSM PEND:
  - Each cycle, retarget to the current sel if it is valid. An invalid sel keeps the previous target.
  - If sel==active_sel: cancel, return to IDLE, deassert uart_hold, clear the timeout counter, no rate_changed.
  - Else if tx_busy==0 and rx_busy==0: go to LOAD.
  - Else, once the timeout counter reaches TIMEOUT_CYC-1, go to LOAD with the forced flag set. Otherwise increment the timeout counter.
- FSM LOAD (1 clk):
  - active_sel<=target; divisor<=DIV[target]; div_cnt<=DIV[target]-1; sub_cnt<=0.
  - rate_changed=1; switch_forced=forced.
  - No tick16/tick1 in this cycle.
  - Clear the timeout counter and forced flag; go to IDLE; uart_hold<=0.
- Latency: sel changes at edge N with the UART idle → uart_hold=1 after edge N+1 → LOAD. active_sel takes the new value and rate_changed pulses after edge N+2, and uart_hold drops on that same edge. The first tick16 at the new rate comes DIV[target] clks after LOAD.
- The old rate keeps ticking unchanged during PEND, so in-flight frames complete at the old rate.
- rst mid-PEND or mid-LOAD returns everything to reset values. No rate_changed pulse is emitted.

Test Plan:
1. Reset, sel=0, busy=0: tick16 period 78 clks, tick1 period 1248 clks, active_sel=0, uart_hold=0.
2. sel 0→4 with busy=0: uart_hold high 1 cycle, rate_changed pulse 2 cycles after the sel change, active_sel=4, then tick16 period 7 and tick1 period 112; switch_forced=0.
3. tx_busy=1, sel 0→2, tx_busy drops after 500 clks: uart_hold stays high the whole time and tick16 keeps period 78. The switch happens 1 cycle after busy drops, then period becomes 20.
4. rx_busy stuck at 1, sel→1, with TIMEOUT_CYC set to 100 for the test: rate_changed and switch_forced pulse together 100 clks into PEND; active_sel=1, period 39.
5. Retarget and cancel in PEND with tx_busy=1: sel 0→3→5→0. Target becomes 3, sel 5 is ignored, sel 0 cancels; uart_hold drops, no rate_changed, active_sel stays 0.
6. rst asserted during PEND (sel=4, busy=1): all outputs return to reset values. After release with sel still 4 and busy=0, the switch completes normally to active_sel=4.
